// File: rtl/button_debouncer_if.sv
// ---------------------------------------------------------------------------
// button_debouncer_if
// Bundles the pushbutton input and the four debouncer outputs so that one
// instance per game button can be wired with a single connection.
//   pb_in     raw pushbutton, asynchronous, active-high, bouncy
//   db_level  debounced button level
//   scen      single-clock enable, one pulse per accepted press
//   mcen      multi-clock enable, press pulse then auto-repeat pulses
//   busy      debouncer is not idle
// master: the side that owns the raw button and consumes the enables.
// slave:  the debouncer itself.
// ---------------------------------------------------------------------------
interface button_debouncer_if;
  logic pb_in;
  logic db_level;
  logic scen;
  logic mcen;
  logic busy;

  modport master (
    output pb_in,
    input  db_level,
    input  scen,
    input  mcen,
    input  busy
  );

  modport slave (
    input  pb_in,
    output db_level,
    output scen,
    output mcen,
    output busy
  );
endinterface

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Per-button debouncer and key-repeat generator. The raw button is brought
// into the clk domain by a two-flop synchroniser, then a state machine with
// a single shared counter accepts presses/releases only after a quiet window
// and produces auto-repeat enables while the button is held.
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   btn   button_debouncer_if.slave (pb_in in; db_level/scen/mcen/busy out)
// Parameters:
//   CNT_W     width of the shared timing counter
//   DEB_CNT   stable cycles needed to accept a press or release
//   HOLD_CNT  cycles held after press before auto-repeat starts
//   RPT_CNT   cycles between auto-repeat pulses
// All counts must be >= 2 and < 2**CNT_W.
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int CNT_W    = 26,
  parameter int DEB_CNT  = 1_000_000,
  parameter int HOLD_CNT = 50_000_000,
  parameter int RPT_CNT  = 10_000_000
) (
  input  logic          clk,
  input  logic          rst,
  button_debouncer_if.slave btn
);

  typedef enum logic [2:0] {
    INI,
    WQ,
    SCEN_ST,
    WH,
    MCEN_ST,
    RPT,
    RLS_WQ
  } state_t;

  // Terminal values are compared before any increment, so the counter
  // never needs to hold a value larger than count-1.
  localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CNT - 1);
  localparam logic [CNT_W-1:0] RPT_TC  = CNT_W'(RPT_CNT - 1);

  logic             s1;
  logic             s2;
  logic             pb_sync;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             db_level_q;
  logic             scen_q;
  logic             mcen_q;
  logic             busy_q;

  // Two-flop synchroniser; nothing else ever looks at pb_in directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn.pb_in;
      s2 <= s1;
    end
  end

  assign pb_sync = s2;

  // State, counter and output registers. Outputs are registered from the
  // next-state decode so they change exactly with the state register but
  // never glitch on an encoding transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INI;
      count_q    <= '0;
      db_level_q <= 1'b0;
      scen_q     <= 1'b0;
      mcen_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      db_level_q <= (state_d != INI) && (state_d != WQ);
      scen_q     <= (state_d == SCEN_ST);
      mcen_q     <= (state_d == SCEN_ST) || (state_d == MCEN_ST);
      busy_q     <= (state_d != INI);
    end
  end

  // Next-state and counter logic. In the held states a release is checked
  // first so it wins over a terminal count on the same edge. A bounce during
  // the release wait restarts the quiet window instead of re-pressing, so a
  // new scen can only come after passing back through INI.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      INI: begin
        count_d = '0;
        if (pb_sync) state_d = WQ;
      end
      WQ: begin
        if (!pb_sync) begin
          state_d = INI;
          count_d = '0;
        end else if (count_q == DEB_TC) begin
          state_d = SCEN_ST;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      SCEN_ST: begin
        state_d = WH;
        count_d = '0;
      end
      WH: begin
        if (!pb_sync) begin
          state_d = RLS_WQ;
          count_d = '0;
        end else if (count_q == HOLD_TC) begin
          state_d = MCEN_ST;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      MCEN_ST: begin
        state_d = RPT;
        count_d = '0;
      end
      RPT: begin
        if (!pb_sync) begin
          state_d = RLS_WQ;
          count_d = '0;
        end else if (count_q == RPT_TC) begin
          state_d = MCEN_ST;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      RLS_WQ: begin
        if (pb_sync) begin
          count_d = '0;
        end else if (count_q == DEB_TC) begin
          state_d = INI;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = INI;
        count_d = '0;
      end
    endcase
  end

  assign btn.db_level = db_level_q;
  assign btn.scen     = scen_q;
  assign btn.mcen     = mcen_q;
  assign btn.busy     = busy_q;

endmodule
